// File: rtl/vending_pkg.sv
// Shared types and coin values for the soda vending controller family.
package vending_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE   = 2'b00,
    COIN_NICKEL = 2'b01,
    COIN_DIME   = 2'b10
  } coin_e;

  localparam int NICKEL_C  = 5;
  localparam int DIME_C    = 10;
  localparam int QUARTER_C = 25;

endpackage

// File: rtl/vending_change_sel.sv
// Picks the next change coin for a given credit: dimes while at least 10c remain, then a nickel.
module vending_change_sel
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit_i,
  output logic [1:0]          coin_o,
  output logic [CREDIT_W-1:0] value_o
);

  always_comb begin
    if (credit_i >= CREDIT_W'(DIME_C)) begin
      coin_o  = COIN_DIME;
      value_o = CREDIT_W'(DIME_C);
    end else begin
      coin_o  = COIN_NICKEL;
      value_o = CREDIT_W'(NICKEL_C);
    end
  end

endmodule

// File: rtl/vending_ctrl.sv
// Soda vending controller: collects coins, vends over valid/ready, then returns change
// one coin per handshake. All outputs are decoded from registered state and credit.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int PRICE    = 20,
  parameter int CREDIT_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                nickel_i,
  input  logic                dime_i,
  input  logic                quarter_i,
  input  logic                cancel_i,
  output logic                soda_valid_o,
  input  logic                soda_ready_i,
  output logic                change_valid_o,
  output logic [1:0]          change_coin_o,
  input  logic                change_ready_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    vend_count_o
);

  // Largest reachable credit is PRICE-5 plus a quarter, i.e. PRICE+20.
  if (PRICE < 5 || (PRICE % 5) != 0 || (PRICE + 20) >= (2 ** CREDIT_W)) begin : g_bad_params
    $error("vending_ctrl: PRICE must be a multiple of 5, >= 5, and PRICE+20 must fit CREDIT_W");
  end

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [CREDIT_W-1:0] coin_val, credit_add, chg_val;
  logic [1:0]          chg_coin;

  vending_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
    .credit_i (credit_q),
    .coin_o   (chg_coin),
    .value_o  (chg_val)
  );

  // One coin per cycle; nickel beats dime beats quarter.
  always_comb begin
    coin_val = '0;
    if (nickel_i)       coin_val = CREDIT_W'(NICKEL_C);
    else if (dime_i)    coin_val = CREDIT_W'(DIME_C);
    else if (quarter_i) coin_val = CREDIT_W'(QUARTER_C);
  end

  assign credit_add = credit_q + coin_val;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    cnt_d    = cnt_q;
    case (state_q)
      COLLECT: begin
        credit_d = credit_add;
        // Cancel outranks reaching the price in the same cycle.
        if (cancel_i && credit_add != '0) state_d = CHANGE;
        else if (credit_add >= PRICE_C)   state_d = VEND;
      end
      VEND: begin
        if (soda_ready_i) begin
          credit_d = credit_q - PRICE_C;
          cnt_d    = cnt_q + 1'b1;
          state_d  = (credit_q == PRICE_C) ? COLLECT : CHANGE;
        end
      end
      CHANGE: begin
        if (change_ready_i) begin
          credit_d = credit_q - chg_val;
          if (credit_q == chg_val) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
    end
  end

  assign soda_valid_o   = (state_q == VEND);
  assign change_valid_o = (state_q == CHANGE);
  assign change_coin_o  = (state_q == CHANGE) ? chg_coin : COIN_NONE;
  assign busy_o         = (state_q != COLLECT);
  assign credit_o       = credit_q;
  assign vend_count_o   = cnt_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl: a PRICE=20 and a PRICE=35 instance share one stimulus bus.
module tb_vending_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic nickel, dime, quarter, cancel, soda_rdy, chg_rdy;

  logic       sv20, cv20, busy20;
  logic [1:0] coin20;
  logic [7:0] cr20;
  logic [15:0] cnt20;

  logic       sv35, cv35, busy35;
  logic [1:0] coin35;
  logic [7:0] cr35;
  logic [15:0] cnt35;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vending_ctrl #(.PRICE(20), .CREDIT_W(8), .CNT_W(16)) u_dut20 (
    .clk_i(clk), .rst_ni(rst_n), .nickel_i(nickel), .dime_i(dime), .quarter_i(quarter),
    .cancel_i(cancel), .soda_valid_o(sv20), .soda_ready_i(soda_rdy), .change_valid_o(cv20),
    .change_coin_o(coin20), .change_ready_i(chg_rdy), .credit_o(cr20), .busy_o(busy20),
    .vend_count_o(cnt20)
  );

  vending_ctrl #(.PRICE(35), .CREDIT_W(8), .CNT_W(16)) u_dut35 (
    .clk_i(clk), .rst_ni(rst_n), .nickel_i(nickel), .dime_i(dime), .quarter_i(quarter),
    .cancel_i(cancel), .soda_valid_o(sv35), .soda_ready_i(soda_rdy), .change_valid_o(cv35),
    .change_coin_o(coin35), .change_ready_i(chg_rdy), .credit_o(cr35), .busy_o(busy35),
    .vend_count_o(cnt35)
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    nickel = 0; dime = 0; quarter = 0; cancel = 0; soda_rdy = 0; chg_rdy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (cr20 !== 8'd0) begin n_fail++; $display("FAIL rst_credit: got %0d want 0", cr20); end
    n_chk++; if ({sv20, cv20, busy20} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {sv20, cv20, busy20}); end
    n_chk++; if (coin20 !== 2'b00) begin n_fail++; $display("FAIL rst_coin: got %b want 00", coin20); end
    n_chk++; if (cnt20 !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", cnt20); end
  endtask

  task automatic test_quarter_vend();
    do_reset();
    quarter = 1; tick(); quarter = 0;
    n_chk++; if (cr20 !== 8'd25) begin n_fail++; $display("FAIL qv_credit: got %0d want 25", cr20); end
    n_chk++; if ({sv20, cv20, busy20} !== 3'b101) begin n_fail++; $display("FAIL qv_vend_flags: got %b want 101", {sv20, cv20, busy20}); end
    soda_rdy = 1; tick(); soda_rdy = 0;
    n_chk++; if (cr20 !== 8'd5) begin n_fail++; $display("FAIL qv_after_vend_credit: got %0d want 5", cr20); end
    n_chk++; if ({sv20, cv20, coin20} !== 4'b0101) begin n_fail++; $display("FAIL qv_change_nickel: got %b want 0101", {sv20, cv20, coin20}); end
    n_chk++; if (cnt20 !== 16'd1) begin n_fail++; $display("FAIL qv_count: got %0d want 1", cnt20); end
    chg_rdy = 1; tick(); chg_rdy = 0;
    n_chk++; if ({cr20, cv20, coin20, busy20} !== {8'd0, 1'b0, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL qv_done: got credit %0d cv %b coin %b busy %b want 0 0 00 0", cr20, cv20, coin20, busy20); end
    n_chk++; if (cnt20 !== 16'd1) begin n_fail++; $display("FAIL qv_count_end: got %0d want 1", cnt20); end
  endtask

  task automatic test_nickels();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      nickel = 1; tick(); nickel = 0;
      n_chk++; if (cr20 !== 8'(5 * i)) begin n_fail++; $display("FAIL nk_credit%0d: got %0d want %0d", i, cr20, 5 * i); end
      n_chk++; if (sv20 !== (i == 4)) begin n_fail++; $display("FAIL nk_valid%0d: got %b want %b", i, sv20, (i == 4)); end
      if (i < 4) tick();
    end
    soda_rdy = 1; tick(); soda_rdy = 0;
    n_chk++; if ({cr20, sv20, cv20, busy20} !== {8'd0, 3'b000}) begin
      n_fail++; $display("FAIL nk_exact: got credit %0d sv %b cv %b busy %b want 0 0 0 0", cr20, sv20, cv20, busy20); end
    n_chk++; if (cnt20 !== 16'd1) begin n_fail++; $display("FAIL nk_count: got %0d want 1", cnt20); end
  endtask

  task automatic test_cancel();
    do_reset();
    dime = 1; tick(); dime = 0;
    cancel = 1; tick(); cancel = 0;
    n_chk++; if ({cv20, coin20, sv20} !== 4'b1100) begin n_fail++; $display("FAIL cn_dime: got %b want 1100", {cv20, coin20, sv20}); end
    n_chk++; if (cr20 !== 8'd10) begin n_fail++; $display("FAIL cn_credit: got %0d want 10", cr20); end
    chg_rdy = 1; tick(); chg_rdy = 0;
    n_chk++; if ({cr20, busy20, cnt20} !== {8'd0, 1'b0, 16'd0}) begin
      n_fail++; $display("FAIL cn_done: got credit %0d busy %b count %0d want 0 0 0", cr20, busy20, cnt20); end
    cancel = 1; tick(); cancel = 0;
    n_chk++; if ({cv20, busy20, cr20} !== {2'b00, 8'd0}) begin
      n_fail++; $display("FAIL cn_zero: got cv %b busy %b credit %0d want 0 0 0", cv20, busy20, cr20); end
    // Quarter plus cancel: the refund wins over the vend.
    quarter = 1; cancel = 1; tick(); quarter = 0; cancel = 0;
    n_chk++; if ({sv20, cv20, coin20, cr20} !== {4'b0110, 8'd25}) begin
      n_fail++; $display("FAIL cn_race: got sv %b cv %b coin %b credit %0d want 0 1 10 25", sv20, cv20, coin20, cr20); end
    chg_rdy = 1;
    tick();
    n_chk++; if ({coin20, cr20} !== {2'b10, 8'd15}) begin n_fail++; $display("FAIL cn_b2b1: got coin %b credit %0d want 10 15", coin20, cr20); end
    tick();
    n_chk++; if ({coin20, cr20} !== {2'b01, 8'd5}) begin n_fail++; $display("FAIL cn_b2b2: got coin %b credit %0d want 01 5", coin20, cr20); end
    tick(); chg_rdy = 0;
    n_chk++; if ({cv20, busy20, cr20, cnt20} !== {2'b00, 8'd0, 16'd0}) begin
      n_fail++; $display("FAIL cn_b2b_end: got cv %b busy %b credit %0d count %0d want 0 0 0 0", cv20, busy20, cr20, cnt20); end
  endtask

  task automatic test_stall();
    do_reset();
    quarter = 1; tick(); quarter = 0;
    for (int i = 0; i < 5; i++) begin
      dime = 1; tick(); dime = 0;
      n_chk++; if ({sv20, busy20, cr20} !== {2'b11, 8'd25}) begin
        n_fail++; $display("FAIL st_hold%0d: got sv %b busy %b credit %0d want 1 1 25", i, sv20, busy20, cr20); end
    end
    soda_rdy = 1; tick(); soda_rdy = 0;
    n_chk++; if ({cr20, cv20, coin20} !== {8'd5, 3'b101}) begin
      n_fail++; $display("FAIL st_release: got credit %0d cv %b coin %b want 5 1 01", cr20, cv20, coin20); end
  endtask

  task automatic test_price35();
    do_reset();
    dime = 1; tick(); dime = 0;
    n_chk++; if ({cr35, sv35} !== {8'd10, 1'b0}) begin n_fail++; $display("FAIL p35_dime: got credit %0d sv %b want 10 0", cr35, sv35); end
    quarter = 1; tick(); quarter = 0;
    n_chk++; if ({cr35, sv35} !== {8'd35, 1'b1}) begin n_fail++; $display("FAIL p35_exact: got credit %0d sv %b want 35 1", cr35, sv35); end
    soda_rdy = 1; tick(); soda_rdy = 0;
    n_chk++; if ({cr35, cv35, busy35, cnt35} !== {8'd0, 2'b00, 16'd1}) begin
      n_fail++; $display("FAIL p35_nochg: got credit %0d cv %b busy %b count %0d want 0 0 0 1", cr35, cv35, busy35, cnt35); end
    quarter = 1; tick(); tick(); quarter = 0;
    n_chk++; if ({cr35, sv35} !== {8'd50, 1'b1}) begin n_fail++; $display("FAIL p35_50: got credit %0d sv %b want 50 1", cr35, sv35); end
    soda_rdy = 1; tick(); soda_rdy = 0;
    n_chk++; if ({cr35, cv35, coin35} !== {8'd15, 3'b110}) begin
      n_fail++; $display("FAIL p35_chg1: got credit %0d cv %b coin %b want 15 1 10", cr35, cv35, coin35); end
    chg_rdy = 1; tick();
    n_chk++; if ({cr35, cv35, coin35} !== {8'd5, 3'b101}) begin
      n_fail++; $display("FAIL p35_chg2: got credit %0d cv %b coin %b want 5 1 01", cr35, cv35, coin35); end
    tick(); chg_rdy = 0;
    n_chk++; if ({cr35, busy35, cnt35} !== {8'd0, 1'b0, 16'd2}) begin
      n_fail++; $display("FAIL p35_end: got credit %0d busy %b count %0d want 0 0 2", cr35, busy35, cnt35); end
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    quarter = 1; tick(); quarter = 0;
    soda_rdy = 1; tick(); soda_rdy = 0;
    tick();
    n_chk++; if (cv20 !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got cv %b want 1", cv20); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({sv20, cv20, coin20, busy20, cr20, cnt20} !== {5'b00000, 8'd0, 16'd0}) begin
      n_fail++; $display("FAIL rm_async: got sv %b cv %b coin %b busy %b credit %0d count %0d want all 0",
                         sv20, cv20, coin20, busy20, cr20, cnt20); end
    tick();
    rst_n = 1'b1;
    nickel = 1; dime = 1; tick(); nickel = 0; dime = 0;
    n_chk++; if (cr20 !== 8'd5) begin n_fail++; $display("FAIL rm_prio: got credit %0d want 5", cr20); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    test_reset();
    test_quarter_vend();
    test_nickels();
    test_cancel();
    test_stall();
    test_price35();
    test_reset_mid_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_ctrl.md
# vending_ctrl

Parametrised soda vending controller. Accumulates nickel/dime/quarter credit toward a configurable price and hands the soda to a downstream dispenser over a valid/ready handshake. It then pays change, or refunds on cancel, one coin per handshake, dimes first, to a coin-return mechanism. It sits between the coin acceptor front end and the dispenser/coin-return actuators, and keeps a running vend counter for the status block.

## Interface
Parameters:
- PRICE, 20, soda price in cents; multiple of 5, ≥ 5
- CREDIT_W, 8, credit register width; elaboration-time check that PRICE+20 < 2**CREDIT_W
- CNT_W, 16, vend counter width

Ports:
- clk_i  input  1  single clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- nickel_i  input  1  5¢ coin pulse, one cycle per coin
- dime_i  input  1  10¢ coin pulse
- quarter_i  input  1  25¢ coin pulse
- cancel_i  input  1  refund request pulse
- soda_valid_o  output  1  vend request to dispenser
- soda_ready_i  input  1  dispenser accepts vend
- change_valid_o  output  1  coin-return request
- change_coin_o  output  2  coin to return: 2'b01 nickel, 2'b10 dime, 2'b00 when not valid
- change_ready_i  input  1  coin-return accepts coin
- credit_o  output  CREDIT_W  current credit in cents
- busy_o  output  1  high when not in COLLECT; coins ignored
- vend_count_o  output  CNT_W  completed vends, wraps modulo 2**CNT_W

## Operation
- States: COLLECT, VEND, CHANGE.
- Reset values: state COLLECT; credit_o 0; vend_count_o 0; all valid outputs 0; change_coin_o 2'b00.
- COLLECT:
  - Coin acceptance: at most one coin is accepted per cycle. Priority is nickel > dime > quarter; lower-priority coins in the same cycle are dropped.
  - On an accepted coin, credit ← credit + value.
  - If credit + value ≥ PRICE, next state is VEND.
  - cancel_i with credit + value > 0 → CHANGE, refunding the whole credit. A coin in the same cycle is added first. Cancel is ignored when the credit would be 0.
  - If the new credit reaches PRICE in the same cycle as cancel_i, cancel wins and the controller goes to CHANGE, not VEND.
- VEND:
  - soda_valid_o = 1, held until soda_valid_o & soda_ready_i at a rising edge.
  - On that transfer: credit ← credit − PRICE and vend_count_o + 1.
  - Next state is COLLECT if the remaining credit is 0, otherwise CHANGE.
- CHANGE:
  - change_valid_o = 1.
  - change_coin_o = dime if credit ≥ 10, else nickel.
  - On a transfer: credit ← credit − coin value. When the credit reaches 0, next state is COLLECT.
- In VEND and CHANGE, coin and cancel inputs are ignored and lost; the upstream acceptor must gate on busy_o.
- Credit arithmetic is unsigned CREDIT_W-bit. Overflow cannot occur given the parameter check. Credit is always a multiple of 5.

## Timing
- Coin in cycle N → credit_o updated in N+1. If the price is reached, soda_valid_o = 1 in N+1.
- All outputs are registered, or Moore-decoded from registered state/credit; there are no input-to-output combinational paths.
- A soda transfer at edge M gives credit_o and vend_count_o updated in M+1. change_valid_o rises in M+1 if credit remains.
- Each change coin takes a minimum of 1 cycle; back-to-back transfers are allowed when ready is held high.
- Valid, once raised, never drops and change_coin_o never changes until the transfer completes.
- rst_ni asserted in any state, mid-handshake included, forces reset values immediately. Any pending credit is lost.

## Structure
- Package vending_pkg:
  - state_e enum (COLLECT, VEND, CHANGE)
  - coin_e enum (COIN_NONE=2'b00, COIN_NICKEL=2'b01, COIN_DIME=2'b10)
  - value constants NICKEL_C=5, DIME_C=10, QUARTER_C=25
- One sub-module, vending_change_sel: combinational; takes the credit and returns the next change coin and its value. Shared with the future multi-price variant.
- Top module holds the FSM, the credit register and the vend counter.

## Test plan
- PRICE=20: reset, quarter → credit_o=25 and soda_valid_o=1 next cycle. Ready → credit 5, change_coin_o=nickel. Ready → credit 0, COLLECT, vend_count_o=1.
- PRICE=20: nickel ×4 on separate cycles → soda_valid_o after the 4th coin. Transfer → credit 0, no change_valid_o.
- PRICE=20: dime, then cancel → change_coin_o=dime, then COLLECT. vend_count_o stays 0. A cancel with credit 0 produces no response.
- PRICE=20: quarter, then soda_ready_i low for 5 cycles while dimes are pulsed → soda_valid_o held, credit_o stays 25, busy_o=1.
- PRICE=35: dime+quarter → exact vend, no change. Quarter, quarter → 50, then change dime then nickel (15 total).
- Reset asserted mid-CHANGE with ready low → all outputs at reset values asynchronously. nickel_i+dime_i in the same cycle afterwards → credit_o=5.
